// File: rtl/mem_pkg.sv
// Shared types and width helpers for the memory-subsystem Wishbone arbiter.
// Widths are derived from the arbiter parameters so every user agrees on them.
package mem_pkg;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // One extra bit so the count can hold MAX_OUT itself.
    function automatic int oc_width(input int max_out);
        return $clog2(max_out) + 1;
    endfunction

    function automatic int wd_width(input int timeout);
        return (timeout > 2) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NM.
// Rotate, priority-encode, un-rotate; also usable for cache way replacement.
module rr_pick
    import mem_pkg::*;
#(
    parameter int NM = 2
) (
    input  logic [NM-1:0]            req,
    input  logic [idx_width(NM)-1:0] ptr,
    output logic                     any,
    output logic [idx_width(NM)-1:0] idx
);
    localparam int IW = idx_width(NM);

    logic [NM-1:0] rot;
    int            enc;

    always_comb begin
        rot = '0;
        for (int i = 0; i < NM; i++) begin
            rot[i] = req[(i + int'(ptr)) % NM];
        end
        enc = 0;
        for (int i = NM - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = i;
            end
        end
        any = |req;
        idx = IW'((enc + int'(ptr)) % NM);
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// N-master to 1-slave pipelined Wishbone arbiter with round-robin grant,
// per-cycle bus lock, outstanding-strobe cap and a no-response watchdog.
module wb_mem_arbiter
    import mem_pkg::*;
#(
    parameter int NM      = 2,
    parameter int AW      = 18,
    parameter int DW      = 32,
    parameter int MAX_OUT = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                 cpu_clock_i,
    input  logic                 cpu_reset_ni,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    output logic [NM-1:0]        m_stall_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [DW-1:0]        m_dat_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic                 s_we_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    input  logic                 s_stall_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    input  logic [DW-1:0]        s_dat_i
);
    localparam int IW = idx_width(NM);
    localparam int OW = oc_width(MAX_OUT);
    localparam int WW = wd_width(TIMEOUT);
    localparam int SW = DW / 8;

    arb_state_t    state, state_n;
    logic [IW-1:0] g, g_n, p, p_n, win;
    logic [OW-1:0] oc, oc_n;
    logic [WW-1:0] wd, wd_n;
    logic          any, granted, limit, timeout;
    logic          rel, cyc_g, stb_g, inc, done;

    rr_pick #(.NM(NM)) u_pick (
        .req (m_cyc_i),
        .ptr (p),
        .any (any),
        .idx (win)
    );

    assign granted = (state == GRANT);
    assign limit   = granted && (oc == OW'(MAX_OUT));
    assign timeout = granted && (wd == WW'(TIMEOUT - 1));
    assign cyc_g   = granted && m_cyc_i[g] && !timeout;
    assign stb_g   = cyc_g && m_stb_i[g] && !limit;
    assign inc     = stb_g && !s_stall_i;
    assign done    = cyc_g && (s_ack_i || s_err_i);
    assign rel     = granted && (!m_cyc_i[g] || timeout);

    always_comb begin
        s_cyc_o   = cyc_g;
        s_stb_o   = stb_g;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        s_sel_o   = '0;
        m_stall_o = '1;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_dat_o   = s_dat_i;
        if (granted) begin
            s_we_o       = m_we_i[g];
            s_adr_o      = m_adr_i[int'(g) * AW +: AW];
            s_dat_o      = m_dat_i[int'(g) * DW +: DW];
            s_sel_o      = m_sel_i[int'(g) * SW +: SW];
            m_stall_o[g] = s_stall_i || limit;
            m_ack_o[g]   = s_ack_i && cyc_g;
            m_err_o[g]   = (s_err_i && cyc_g) || timeout;
        end
    end

    // Arbitrate from IDLE or on release, so handover costs no idle cycle.
    always_comb begin
        state_n = state;
        g_n     = g;
        p_n     = p;
        oc_n    = oc;
        wd_n    = wd;
        if (!granted || rel) begin
            oc_n = '0;
            wd_n = '0;
            if (any) begin
                state_n = GRANT;
                g_n     = win;
                p_n     = (win == IW'(NM - 1)) ? '0 : win + 1'b1;
            end else begin
                state_n = IDLE;
            end
        end else begin
            if (inc && !done) begin
                oc_n = oc + 1'b1;
            end else if (done && !inc && oc != '0) begin
                oc_n = oc - 1'b1;
            end
            if (oc != '0 && !done) begin
                wd_n = wd + 1'b1;
            end else begin
                wd_n = '0;
            end
        end
    end

    always_ff @(posedge cpu_clock_i or negedge cpu_reset_ni) begin
        if (!cpu_reset_ni) begin
            state <= IDLE;
            g     <= '0;
            p     <= '0;
            oc    <= '0;
            wd    <= '0;
        end else begin
            state <= state_n;
            g     <= g_n;
            p     <= p_n;
            oc    <= oc_n;
            wd    <= wd_n;
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: vector table, directed corner sequences,
// then randomized traffic against a cycle reference model.
module tb_wb_mem_arbiter;
    localparam int NM = 3;
    localparam int AW = 18;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MAX_OUT = 4;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NM-1:0]     m_cyc, m_stb, m_we;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*SW-1:0]  m_sel;
    logic [NM-1:0]     m_stall, m_ack, m_err;
    logic [DW-1:0]     m_rdat;
    logic              s_cyc, s_stb, s_we;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_wdat;
    logic [SW-1:0]     s_sel;
    logic              s_stall, s_ack, s_err;
    logic [DW-1:0]     s_dat;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_mem_arbiter #(
        .NM(NM), .AW(AW), .DW(DW),
        .MAX_OUT(MAX_OUT), .TIMEOUT(TIMEOUT)
    ) dut (
        .cpu_clock_i (clk),
        .cpu_reset_ni(rst_n),
        .m_cyc_i     (m_cyc),
        .m_stb_i     (m_stb),
        .m_we_i      (m_we),
        .m_adr_i     (m_adr),
        .m_dat_i     (m_dat),
        .m_sel_i     (m_sel),
        .m_stall_o   (m_stall),
        .m_ack_o     (m_ack),
        .m_err_o     (m_err),
        .m_dat_o     (m_rdat),
        .s_cyc_o     (s_cyc),
        .s_stb_o     (s_stb),
        .s_we_o      (s_we),
        .s_adr_o     (s_adr),
        .s_dat_o     (s_wdat),
        .s_sel_o     (s_sel),
        .s_stall_i   (s_stall),
        .s_ack_i     (s_ack),
        .s_err_i     (s_err),
        .s_dat_i     (s_dat)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        m_cyc   = '0;
        m_stb   = '0;
        s_stall = 1'b0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        s_dat   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [NM-1:0] cyc;
        logic [NM-1:0] stb;
        logic          stall;
        logic          ack;
        logic [DW-1:0] dat;
        logic          e_cyc;
        logic          e_stb;
        logic [NM-1:0] e_stall;
        logic [NM-1:0] e_ack;
        logic [AW-1:0] e_adr;
    } vec_t;

    vec_t tv [16];

    // Reference model: owner index (-1 idle), rotating pointer,
    // accepted-but-unanswered strobes and silent cycles.
    int owner, ptr, outs, silent;
    logic          e_cyc, e_stb, e_we, to, lim;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_wdat;
    logic [SW-1:0] e_sel;
    logic [NM-1:0] e_stall, e_ack, e_err;

    task automatic model_eval();
        to  = (owner >= 0) && (silent == TIMEOUT - 1);
        lim = (owner >= 0) && (outs == MAX_OUT);
        e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
        e_adr = '0; e_wdat = '0; e_sel = '0;
        e_stall = '1; e_ack = '0; e_err = '0;
        if (owner >= 0) begin
            e_cyc  = m_cyc[owner] && !to;
            e_stb  = e_cyc && m_stb[owner] && !lim;
            e_we   = m_we[owner];
            e_adr  = m_adr[owner*AW +: AW];
            e_wdat = m_dat[owner*DW +: DW];
            e_sel  = m_sel[owner*SW +: SW];
            e_stall[owner] = s_stall || lim;
            e_ack[owner]   = s_ack && e_cyc;
            e_err[owner]   = (s_err && e_cyc) || to;
        end
    endtask

    task automatic model_step();
        int nw;
        bit fin, acc;
        if (owner < 0 || !m_cyc[owner] || to) begin
            nw = -1;
            for (int i = 0; i < NM; i++) begin
                if (nw < 0 && m_cyc[(ptr + i) % NM]) nw = (ptr + i) % NM;
            end
            if (nw >= 0) ptr = (nw + 1) % NM;
            owner  = nw;
            outs   = 0;
            silent = 0;
        end else begin
            fin = (s_ack || s_err) && e_cyc;
            acc = e_stb && !s_stall;
            silent = (outs > 0 && !fin) ? silent + 1 : 0;
            if (acc && !fin) outs++;
            else if (fin && !acc && outs > 0) outs--;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_time_limit: got expired expected finished");
        $fatal(1);
    end

    initial begin
        int acc, n, stalls, acks;
        bit found;
        rst_n = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = 3'b010;
        m_adr = {18'h12, 18'h11, 18'h10};
        m_dat = {32'hC0C0C0C0, 32'hB1B1B1B1, 32'hA0A0A0A0};
        m_sel = {4'hC, 4'h3, 4'hF};
        s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_dat = '0;

        tv[0]  = '{3'b001, 3'b001, 0, 0, 32'h0, 0, 0, 3'b111, 3'b000, 18'h0};
        tv[1]  = '{3'b001, 3'b001, 0, 0, 32'h0, 1, 1, 3'b110, 3'b000, 18'h10};
        tv[2]  = '{3'b001, 3'b000, 0, 0, 32'h0, 1, 0, 3'b110, 3'b000, 18'h10};
        tv[3]  = '{3'b001, 3'b000, 0, 1, 32'hDEADBEEF,
                   1, 0, 3'b110, 3'b001, 18'h10};
        tv[4]  = '{3'b000, 3'b000, 0, 0, 32'h0, 0, 0, 3'b110, 3'b000, 18'h10};
        tv[5]  = '{3'b000, 3'b000, 0, 0, 32'h0, 0, 0, 3'b111, 3'b000, 18'h0};
        tv[6]  = '{3'b011, 3'b000, 0, 0, 32'h0, 0, 0, 3'b111, 3'b000, 18'h0};
        tv[7]  = '{3'b011, 3'b010, 0, 0, 32'h0, 1, 1, 3'b101, 3'b000, 18'h11};
        tv[8]  = '{3'b011, 3'b000, 0, 1, 32'h12345678,
                   1, 0, 3'b101, 3'b010, 18'h11};
        tv[9]  = '{3'b001, 3'b000, 0, 0, 32'h0, 0, 0, 3'b101, 3'b000, 18'h11};
        tv[10] = '{3'b011, 3'b001, 0, 0, 32'h0, 1, 1, 3'b110, 3'b000, 18'h10};
        tv[11] = '{3'b011, 3'b000, 0, 1, 32'hCAFEF00D,
                   1, 0, 3'b110, 3'b001, 18'h10};
        tv[12] = '{3'b010, 3'b000, 0, 0, 32'h0, 0, 0, 3'b110, 3'b000, 18'h10};
        tv[13] = '{3'b010, 3'b010, 0, 0, 32'h0, 1, 1, 3'b101, 3'b000, 18'h11};
        tv[14] = '{3'b000, 3'b000, 0, 0, 32'h0, 0, 0, 3'b101, 3'b000, 18'h11};
        tv[15] = '{3'b000, 3'b000, 0, 0, 32'h0, 0, 0, 3'b111, 3'b000, 18'h0};

        #1;
        chk("reset_s_cyc", s_cyc, 0);
        chk("reset_m_stall", m_stall, 3'b111);
        chk("reset_m_ack", m_ack, 0);
        chk("reset_s_adr", s_adr, 0);

        // Single read then alternating contention.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            m_cyc = tv[i].cyc; m_stb = tv[i].stb;
            s_stall = tv[i].stall; s_ack = tv[i].ack; s_dat = tv[i].dat;
            #1;
            chk($sformatf("tv%0d_s_cyc", i), s_cyc, tv[i].e_cyc);
            chk($sformatf("tv%0d_s_stb", i), s_stb, tv[i].e_stb);
            chk($sformatf("tv%0d_m_stall", i), m_stall, tv[i].e_stall);
            chk($sformatf("tv%0d_m_ack", i), m_ack, tv[i].e_ack);
            chk($sformatf("tv%0d_s_adr", i), s_adr, tv[i].e_adr);
            chk($sformatf("tv%0d_m_dat", i), m_rdat, tv[i].dat);
        end

        // Outstanding cap: 4 strobes, then one per ack.
        do_reset();
        m_cyc = 3'b001; m_stb = 3'b001;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            acc += int'(s_stb && !s_stall);
        end
        chk("limit_accepted", acc, 4);
        chk("limit_stall", m_stall[0], 1);
        @(negedge clk); s_ack = 1'b1; #1;
        chk("limit_ack", m_ack[0], 1);
        acc = int'(s_stb);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); s_ack = 1'b0; #1;
            acc += int'(s_stb && !s_stall);
        end
        chk("limit_after_ack", acc, 1);

        // Watchdog: single strobe never answered.
        do_reset();
        m_cyc = 3'b011; m_stb = 3'b001;
        @(negedge clk); #1;
        chk("to_strobe", s_stb, 1);
        n = 0; found = 0;
        for (int k = 1; k <= 40 && !found; k++) begin
            @(negedge clk); m_stb = '0; #1;
            if (m_err[0]) begin
                found = 1; n = k;
                chk("to_s_cyc_drop", s_cyc, 0);
            end
        end
        chk("to_cycle", n, 16);
        @(negedge clk); #1;
        chk("to_next_grant", m_stall, 3'b101);
        chk("to_next_adr", s_adr, 18'h11);

        // Bus lock: M1 4-beat burst while M0 waits.
        do_reset();
        m_cyc = 3'b010; m_stb = 3'b010;
        stalls = 0; acc = 0; acks = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            m_cyc = (c < 5) ? 3'b011 : 3'b001;
            m_stb = (c < 4) ? 3'b010 : 3'b000;
            s_ack = (c >= 1 && c <= 4);
            #1;
            stalls += int'(m_stall[0]);
            acc += int'(s_stb && !s_stall);
            acks += int'(m_ack[1]);
        end
        chk("lock_m0_stalled", stalls, 6);
        chk("lock_beats", acc, 4);
        chk("lock_acks", acks, 4);
        @(negedge clk); s_ack = 1'b0; m_stb = 3'b001; #1;
        chk("lock_handover", m_stall, 3'b110);
        chk("lock_handover_adr", s_adr, 18'h10);

        // Async reset with three strobes outstanding.
        do_reset();
        m_cyc = 3'b001; m_stb = 3'b001;
        repeat (3) @(negedge clk);
        @(negedge clk); m_stb = '0; m_cyc = 3'b111; s_ack = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_s_cyc", s_cyc, 0);
        chk("rst_mid_s_stb", s_stb, 0);
        chk("rst_mid_m_stall", m_stall, 3'b111);
        chk("rst_mid_m_ack", m_ack, 0);
        @(negedge clk); rst_n = 1'b1; s_ack = 1'b0; #1;
        chk("rst_idle", m_stall, 3'b111);
        @(negedge clk); #1;
        chk("rst_first_grant", m_stall, 3'b110);

        // Randomized traffic vs reference model.
        do_reset();
        owner = -1; ptr = 0; outs = 0; silent = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int k = 0; k < NM; k++) begin
                if (m_cyc[k]) m_cyc[k] = ($urandom_range(7) != 0);
                else m_cyc[k] = ($urandom_range(3) == 0);
                m_stb[k] = m_cyc[k] && ($urandom_range(1) == 1);
                m_we[k] = 1'($urandom);
                m_adr[k*AW +: AW] = AW'($urandom);
                m_dat[k*DW +: DW] = $urandom;
                m_sel[k*SW +: SW] = SW'($urandom);
            end
            s_stall = ($urandom_range(3) == 0);
            s_ack = ((c % 400) < 360) && ($urandom_range(2) == 0);
            s_err = ((c % 400) < 360) && ($urandom_range(31) == 0);
            s_dat = $urandom;
            #1;
            model_eval();
            chk("rnd_s_bus", {s_cyc, s_stb, s_we, s_sel, s_adr},
                {e_cyc, e_stb, e_we, e_sel, e_adr});
            chk("rnd_s_wdat", s_wdat, e_wdat);
            chk("rnd_m_resp", {m_stall, m_ack, m_err},
                {e_stall, e_ack, e_err});
            chk("rnd_m_dat", m_rdat, s_dat);
            model_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
